// File: rtl/neopixel_pkg.sv
// Shared encodings for the neopixel pattern generator: word width, GRB byte offsets
// and animation mode codes.
package neopixel_pkg;

    localparam int unsigned WORD_W = 24;
    localparam int unsigned G_OFF  = 16;
    localparam int unsigned R_OFF  = 8;
    localparam int unsigned B_OFF  = 0;

    typedef enum logic [1:0] {
        ModeSolid  = 2'd0,
        ModeRotate = 2'd1,
        ModeChase  = 2'd2,
        ModeBlank  = 2'd3
    } mode_e;

endpackage

// File: rtl/neopixel_shade.sv
// Combinational colour stage: maps mode, phase and pixel index to a shaded GRB word.
// Each channel byte is right-shifted by the brightness setting.
module neopixel_shade
    import neopixel_pkg::*;
#(
    parameter int unsigned IdxW = 9
) (
    input  mode_e             mode_i,
    input  logic [7:0]        phase_i,
    input  logic [IdxW-1:0]   pix_idx_i,
    input  logic [WORD_W-1:0] color_i,
    input  logic [2:0]        bright_i,
    output logic [WORD_W-1:0] word_o
);

    logic [7:0]        g, r, b;
    logic [WORD_W-1:0] raw;

    always_comb begin
        g   = color_i[G_OFF +: 8];
        r   = color_i[R_OFF +: 8];
        b   = color_i[B_OFF +: 8];
        raw = '0;
        unique case (mode_i)
            ModeSolid:  raw = color_i;
            ModeRotate: begin
                case (phase_i)
                    8'd1:    raw = {r, b, g};
                    8'd2:    raw = {b, g, r};
                    default: raw = color_i;
                endcase
            end
            ModeChase: begin
                if (16'(pix_idx_i) == 16'(phase_i)) raw = color_i;
            end
            ModeBlank: raw = '0;
        endcase
        word_o = {raw[G_OFF +: 8] >> bright_i,
                  raw[R_OFF +: 8] >> bright_i,
                  raw[B_OFF +: 8] >> bright_i};
    end

endmodule

// File: rtl/neopixel_pattern_gen.sv
// Frame source for the neopixel transmitter: NUM_PIXELS colour words then LATCH_WORDS latch
// words per frame. Settings and animation steps only change at frame boundaries.
module neopixel_pattern_gen
    import neopixel_pkg::*;
#(
    parameter int unsigned NUM_PIXELS  = 18,
    parameter int unsigned LATCH_WORDS = 2,
    parameter int unsigned DIV_TICKS   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [1:0]        mode,
    input  logic [WORD_W-1:0] base_color,
    input  logic [2:0]        bright,
    input  logic              rd_next,
    output logic [WORD_W-1:0] pix_data,
    output logic              msg_typ,
    output logic              frame_done,
    output logic [7:0]        phase
);

    localparam int unsigned     TotalWords = NUM_PIXELS + LATCH_WORDS;
    localparam int unsigned     IdxW       = $clog2(TotalWords);
    localparam logic [IdxW-1:0] LastIdx    = IdxW'(TotalWords - 1);
    localparam logic [IdxW-1:0] NumPix     = IdxW'(NUM_PIXELS);
    localparam logic [15:0]     TickLast   = 16'(DIV_TICKS - 1);
    localparam logic [7:0]      ChaseLast  = 8'(NUM_PIXELS - 1);

    logic [IdxW-1:0]   word_idx_q, word_idx_d;
    logic [7:0]        phase_q, phase_d;
    logic              step_pending_q, step_pending_d;
    logic [15:0]       tick_cnt_q, tick_cnt_d;
    logic              armed_q, armed_d;
    mode_e             mode_q, mode_d;
    logic [WORD_W-1:0] color_q, color_d;
    logic [2:0]        bright_q, bright_d;
    logic [WORD_W-1:0] pix_data_q, pix_data_d;
    logic              msg_typ_q, msg_typ_d;
    logic              frame_done_q;
    logic              boundary, tick_term, step;
    logic [WORD_W-1:0] shade_word;

    always_comb begin
        boundary       = rd_next && (word_idx_q == LastIdx);
        tick_term      = tick && (tick_cnt_q == TickLast);
        step           = step_pending_q || tick_term;
        tick_cnt_d     = tick_cnt_q;
        word_idx_d     = word_idx_q;
        phase_d        = phase_q;
        step_pending_d = step_pending_q || tick_term;
        armed_d        = armed_q;
        mode_d         = mode_q;
        color_d        = color_q;
        bright_d       = bright_q;

        if (tick) tick_cnt_d = tick_term ? 16'd0 : tick_cnt_q + 16'd1;
        if (rd_next) word_idx_d = boundary ? '0 : word_idx_q + IdxW'(1);

        // Frame boundary: latch new settings and consume at most one pending step.
        if (boundary) begin
            armed_d        = 1'b1;
            mode_d         = mode_e'(mode);
            color_d        = base_color;
            bright_d       = bright;
            step_pending_d = 1'b0;
            if (mode_d != mode_q) begin
                phase_d = 8'd0;
            end else if (step) begin
                unique case (mode_d)
                    ModeRotate: phase_d = (phase_q >= 8'd2) ? 8'd0 : phase_q + 8'd1;
                    ModeChase:  phase_d = (phase_q >= ChaseLast) ? 8'd0 : phase_q + 8'd1;
                    ModeSolid,
                    ModeBlank:  phase_d = 8'd0;
                endcase
            end
        end

        msg_typ_d  = word_idx_d < NumPix;
        pix_data_d = (armed_d && msg_typ_d) ? shade_word : '0;
    end

    neopixel_shade #(
        .IdxW (IdxW)
    ) u_shade (
        .mode_i    (mode_d),
        .phase_i   (phase_d),
        .pix_idx_i (word_idx_d),
        .color_i   (color_d),
        .bright_i  (bright_d),
        .word_o    (shade_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_idx_q     <= '0;
            phase_q        <= 8'd0;
            step_pending_q <= 1'b0;
            tick_cnt_q     <= 16'd0;
            armed_q        <= 1'b0;
            mode_q         <= ModeBlank;
            color_q        <= '0;
            bright_q       <= 3'd0;
            pix_data_q     <= '0;
            msg_typ_q      <= 1'b1;
            frame_done_q   <= 1'b0;
        end else begin
            word_idx_q     <= word_idx_d;
            phase_q        <= phase_d;
            step_pending_q <= step_pending_d;
            tick_cnt_q     <= tick_cnt_d;
            armed_q        <= armed_d;
            mode_q         <= mode_d;
            color_q        <= color_d;
            bright_q       <= bright_d;
            frame_done_q   <= boundary;
            if (rd_next) begin
                pix_data_q <= pix_data_d;
                msg_typ_q  <= msg_typ_d;
            end
        end
    end

    assign pix_data   = pix_data_q;
    assign msg_typ    = msg_typ_q;
    assign frame_done = frame_done_q;
    assign phase      = phase_q;

endmodule

// File: tb/tb_neopixel_pattern_gen.sv
// Self-checking bench: frame-level vector table, hand sequences for boundary corner cases,
// and randomized traffic checked every cycle against a behavioural frame model.
module tb_neopixel_pattern_gen;

    localparam int NP    = 5;
    localparam int LW    = 2;
    localparam int DIV   = 3;
    localparam int TOTAL = NP + LW;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [23:0] base_color = 24'h0;
    logic [2:0]  bright = 3'd0;
    logic        rd_next = 1'b0;
    logic [23:0] pix_data;
    logic        msg_typ;
    logic        frame_done;
    logic [7:0]  phase;

    int n_cmp = 0;
    int n_bad = 0;

    neopixel_pattern_gen #(
        .NUM_PIXELS  (NP),
        .LATCH_WORDS (LW),
        .DIV_TICKS   (DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .mode       (mode),
        .base_color (base_color),
        .bright     (bright),
        .rd_next    (rd_next),
        .pix_data   (pix_data),
        .msg_typ    (msg_typ),
        .frame_done (frame_done),
        .phase      (phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural frame model ----------------
    int          m_idx, m_phase, m_tcnt, m_mode, m_bri;
    bit          m_pend, m_armed;
    logic [23:0] m_col;
    logic [23:0] e_pix;
    bit          e_msg, e_fd;

    function automatic logic [23:0] ref_word(input int p);
        logic [7:0] c [3];
        logic [7:0] o [3];
        c[0] = m_col[23:16];
        c[1] = m_col[15:8];
        c[2] = m_col[7:0];
        for (int k = 0; k < 3; k++) begin
            case (m_mode)
                0:       o[k] = c[k];
                1:       o[k] = c[(k + m_phase) % 3];
                2:       o[k] = (p == m_phase) ? c[k] : 8'h00;
                default: o[k] = 8'h00;
            endcase
            o[k] = o[k] >> m_bri;
        end
        return {o[0], o[1], o[2]};
    endfunction

    task automatic model_reset();
        m_idx = 0; m_phase = 0; m_tcnt = 0; m_mode = 3; m_bri = 0;
        m_pend = 0; m_armed = 0; m_col = 24'h0;
        e_pix = 24'h0; e_msg = 1; e_fd = 0;
    endtask

    task automatic model_clock();
        bit term, bnd, stp;
        term = tick && (m_tcnt == DIV - 1);
        if (tick) m_tcnt = term ? 0 : m_tcnt + 1;
        bnd  = rd_next && (m_idx == TOTAL - 1);
        e_fd = bnd;
        if (bnd) begin
            stp     = m_pend || term;
            m_pend  = 0;
            m_armed = 1;
            if (int'(mode) != m_mode) m_phase = 0;
            else if (stp && mode == 2'd1) m_phase = (m_phase + 1) % 3;
            else if (stp && mode == 2'd2) m_phase = (m_phase + 1) % NP;
            m_mode = int'(mode);
            m_col  = base_color;
            m_bri  = int'(bright);
        end else if (term) begin
            m_pend = 1;
        end
        if (rd_next) begin
            m_idx = (m_idx + 1) % TOTAL;
            e_msg = m_idx < NP;
            e_pix = (e_msg && m_armed) ? ref_word(m_idx) : 24'h0;
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) model_reset();
        else model_clock();
    end

    always @(negedge clk) begin
        if (rst) begin
            check("model pix_data", 32'(pix_data), 32'(e_pix));
            check("model msg_typ", 32'(msg_typ), 32'(e_msg));
            check("model frame_done", 32'(frame_done), 32'(e_fd));
            check("model phase", 32'(phase), 32'(m_phase));
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        logic [1:0]         mode;
        logic [23:0]        col;
        logic [2:0]         bri;
        int                 ticks;
        int                 ph;
        logic [NP*24-1:0]   exp;
    } row_t;

    row_t rows[$];

    task automatic add(input logic [1:0] md, input logic [23:0] c, input logic [2:0] br,
                       input int tk, input int ph, input logic [NP*24-1:0] e);
        row_t r;
        r.mode = md; r.col = c; r.bri = br; r.ticks = tk; r.ph = ph; r.exp = e;
        rows.push_back(r);
    endtask

    // Drive for one clock; returns at the following negedge.
    task automatic cyc(input logic r, input logic t);
        rd_next = r;
        tick    = t;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Each row: settings applied during a frame, expected words of that same frame
        // (produced by the previous row's settings).
        add(2'd0, 24'h300000, 3'd0, 0, 0, {NP{24'h000000}});
        add(2'd1, 24'h102030, 3'd0, 0, 0, {NP{24'h300000}});
        add(2'd1, 24'h102030, 3'd0, 3, 0, {NP{24'h102030}});
        add(2'd1, 24'h102030, 3'd0, 3, 1, {NP{24'h203010}});
        add(2'd1, 24'h102030, 3'd0, 3, 2, {NP{24'h301020}});
        add(2'd2, 24'hFFFFFF, 3'd0, 3, 0, {NP{24'h102030}});
        add(2'd2, 24'hFFFFFF, 3'd0, 3, 0, {24'hFFFFFF, 24'h0, 24'h0, 24'h0, 24'h0});
        add(2'd2, 24'hFFFFFF, 3'd0, 9, 1, {24'h0, 24'hFFFFFF, 24'h0, 24'h0, 24'h0});
        add(2'd2, 24'hFFFFFF, 3'd0, 0, 2, {24'h0, 24'h0, 24'hFFFFFF, 24'h0, 24'h0});
        add(2'd0, 24'hFF8010, 3'd3, 0, 2, {24'h0, 24'h0, 24'hFFFFFF, 24'h0, 24'h0});
        add(2'd3, 24'h000000, 3'd0, 0, 0, {NP{24'h1F1002}});
        add(2'd0, 24'h123456, 3'd1, 0, 0, {NP{24'h000000}});
        add(2'd0, 24'h123456, 3'd1, 0, 0, {NP{24'h091A2B}});

        // Reset with rd_next held high: must be ignored.
        rst = 1'b0;
        rd_next = 1'b1;
        repeat (3) @(negedge clk);
        check("reset pix_data", 32'(pix_data), 32'h0);
        check("reset msg_typ", 32'(msg_typ), 32'h1);
        check("reset frame_done", 32'(frame_done), 32'h0);
        check("reset phase", 32'(phase), 32'h0);
        rd_next = 1'b0;
        rst = 1'b1;

        foreach (rows[i]) begin
            mode = rows[i].mode; base_color = rows[i].col; bright = rows[i].bri;
            for (int t = 0; t < rows[i].ticks; t++) cyc(1'b0, 1'b1);
            check($sformatf("row%0d phase", i), 32'(phase), 32'(rows[i].ph));
            for (int w = 0; w < TOTAL; w++) begin
                if (w < NP) begin
                    check($sformatf("row%0d word%0d", i, w), 32'(pix_data),
                          32'(rows[i].exp[(NP-1-w)*24 +: 24]));
                    check($sformatf("row%0d msg%0d", i, w), 32'(msg_typ), 32'h1);
                end else begin
                    check($sformatf("row%0d latch%0d", i, w), 32'(pix_data), 32'h0);
                    check($sformatf("row%0d lmsg%0d", i, w), 32'(msg_typ), 32'h0);
                end
                cyc(1'b1, 1'b0);
            end
            check($sformatf("row%0d frame_done", i), 32'(frame_done), 32'h1);
            cyc(1'b0, 1'b0);
            check($sformatf("row%0d frame_done pulse", i), 32'(frame_done), 32'h0);
        end

        // Brightness changed mid-frame must not affect the frame in flight.
        mode = 2'd0; base_color = 24'hFF8010; bright = 3'd3;
        for (int w = 0; w < TOTAL; w++) cyc(1'b1, 1'b0);
        for (int w = 0; w < NP; w++) begin
            if (w == 2) bright = 3'd0;
            check($sformatf("midbright word%0d", w), 32'(pix_data), 32'h1F1002);
            cyc(1'b1, 1'b0);
        end
        for (int w = NP; w < TOTAL; w++) cyc(1'b1, 1'b0);
        check("midbright next frame", 32'(pix_data), 32'hFF8010);

        // Terminal tick coincident with the boundary advances phase exactly once.
        mode = 2'd1; base_color = 24'h102030;
        for (int w = 0; w < TOTAL; w++) cyc(1'b1, 1'b0);
        check("coincide start phase", 32'(phase), 32'h0);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        for (int w = 0; w < TOTAL - 1; w++) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        check("coincide phase", 32'(phase), 32'h1);
        check("coincide word0", 32'(pix_data), 32'h203010);
        for (int w = 0; w < TOTAL; w++) cyc(1'b1, 1'b0);
        check("coincide no carry", 32'(phase), 32'h1);

        // Asynchronous reset mid-frame at word 3.
        for (int w = 0; w < 3; w++) cyc(1'b1, 1'b0);
        rd_next = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("midreset pix_data", 32'(pix_data), 32'h0);
        check("midreset msg_typ", 32'(msg_typ), 32'h1);
        check("midreset frame_done", 32'(frame_done), 32'h0);
        check("midreset phase", 32'(phase), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        mode = 2'd0; base_color = 24'hAABBCC; bright = 3'd0;
        for (int w = 0; w < TOTAL; w++) begin
            if (w < NP) check($sformatf("postreset black%0d", w), 32'(pix_data), 32'h0);
            cyc(1'b1, 1'b0);
        end
        check("postreset normal", 32'(pix_data), 32'hAABBCC);

        // Randomized traffic, checked every cycle by the model.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                mode       = 2'($urandom_range(0, 3));
                base_color = 24'($urandom);
                bright     = 3'($urandom_range(0, 7));
            end
            cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
        end
        cyc(1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
